// File: rtl/ebpc_pkg.sv
// ============================================================================
// Module  : ebpc_pkg
// Purpose : Shared widths, FSM state type and ZRLE symbol type for the EBPC
//           encoder front end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ebpc_pkg;

  localparam int DATA_W    = 8;
  localparam int MAX_ZRL_W = 4;
  localparam int SYM_LEN_W = $clog2(MAX_ZRL_W + 2);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLUSH_RUN = 2'd1,
    FLUSH_OUT = 2'd2,
    IDLE      = 2'd3
  } zrle_state_e;

  // Right-aligned symbol bits plus the number of valid bits in it.
  typedef struct packed {
    logic [MAX_ZRL_W:0]   sym;
    logic [SYM_LEN_W-1:0] len;
  } zrle_sym_t;

  // Symbol for a single nonzero word: one '1' bit.
  function automatic zrle_sym_t zrle_nz_sym();
    zrle_sym_t s;
    s.sym = (MAX_ZRL_W + 1)'(1);
    s.len = SYM_LEN_W'(1);
    return s;
  endfunction

  // Symbol for a zero run; the field carries (run length - 1).
  function automatic zrle_sym_t zrle_run_sym(input logic [MAX_ZRL_W-1:0] len_m1);
    zrle_sym_t s;
    s.sym = {1'b0, len_m1};
    s.len = SYM_LEN_W'(MAX_ZRL_W + 1);
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/zrle_sym_buf.sv
// ============================================================================
// Module  : zrle_sym_buf
// Purpose : Two-entry FIFO of ZRLE symbols with an ordered dual-push port
//           (push_a is written ahead of push_b) and same-cycle push/pop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module zrle_sym_buf
  import ebpc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_a_i,
  input  zrle_sym_t  sym_a_i,
  input  logic       push_b_i,
  input  zrle_sym_t  sym_b_i,
  input  logic       pop_i,
  output zrle_sym_t  head_o,
  output logic [1:0] cnt_o
);

  zrle_sym_t  slot [2];
  zrle_sym_t  slot_nxt [2];
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;

  // Next contents: retire the head first, then append pushes in order.
  always_comb begin
    slot_nxt[0] = slot[0];
    slot_nxt[1] = slot[1];
    cnt_nxt     = cnt;
    if (pop_i && (cnt != 2'd0)) begin
      slot_nxt[0] = slot[1];
      cnt_nxt     = cnt - 2'd1;
    end
    if (push_a_i && (cnt_nxt != 2'd2)) begin
      if (cnt_nxt == 2'd0) slot_nxt[0] = sym_a_i;
      else                 slot_nxt[1] = sym_a_i;
      cnt_nxt = cnt_nxt + 2'd1;
    end
    if (push_b_i && (cnt_nxt != 2'd2)) begin
      if (cnt_nxt == 2'd0) slot_nxt[0] = sym_b_i;
      else                 slot_nxt[1] = sym_b_i;
      cnt_nxt = cnt_nxt + 2'd1;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot[0] <= '0;
      slot[1] <= '0;
      cnt     <= 2'd0;
    end else begin
      slot[0] <= slot_nxt[0];
      slot[1] <= slot_nxt[1];
      cnt     <= cnt_nxt;
    end
  end

  assign head_o = slot[0];
  assign cnt_o  = cnt;

endmodule

`default_nettype wire

// File: rtl/zrle_nz_split.sv
// ============================================================================
// Module  : zrle_nz_split
// Purpose : EBPC front stage. Routes nonzero words to the bit-plane encoder
//           and emits a zero/nonzero run-length symbol stream for the ZRLE
//           packer, then forwards end-of-stream flush to both consumers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module zrle_nz_split #(
  parameter int DATA_W = ebpc_pkg::DATA_W,
  parameter int ZRL_W  = ebpc_pkg::MAX_ZRL_W
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         flush_i,
  input  logic                         vld_i,
  output logic                         rdy_o,
  output logic [DATA_W-1:0]            nz_data_o,
  output logic                         nz_flush_o,
  output logic                         nz_vld_o,
  input  logic                         nz_rdy_i,
  output logic [ZRL_W:0]               sym_o,
  output logic [$clog2(ZRL_W+2)-1:0]   sym_len_o,
  output logic                         sym_flush_o,
  output logic                         sym_vld_o,
  input  logic                         sym_rdy_i,
  output logic                         idle_o
);

  import ebpc_pkg::*;

  localparam logic [1:0]       S_RUN       = RUN;
  localparam logic [1:0]       S_FLUSH_RUN = FLUSH_RUN;
  localparam logic [1:0]       S_FLUSH_OUT = FLUSH_OUT;
  localparam logic [1:0]       S_IDLE      = IDLE;
  localparam logic [ZRL_W-1:0] RUN_MAX     = '1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ZRL_W-1:0]  run_cnt;
  logic [ZRL_W-1:0]  run_nxt;
  logic [DATA_W-1:0] nz_data;
  logic              nz_vld;
  logic              nz_done;
  logic              sym_done;

  logic              push_a;
  logic              push_b;
  zrle_sym_t         sym_a;
  zrle_sym_t         sym_b;
  zrle_sym_t         head;
  logic [1:0]        buf_cnt;
  logic              buf_empty;
  logic              pop;

  logic              nz_room;
  logic              sym_room2;
  logic              slot_free;
  logic              accept;
  logic              in_zero;
  logic              nz_fl_fire;
  logic              sym_fl_fire;
  logic              nz_fl_ok;
  logic              sym_fl_ok;

  zrle_sym_buf u_sym_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_a_i (push_a),
    .sym_a_i  (sym_a),
    .push_b_i (push_b),
    .sym_b_i  (sym_b),
    .pop_i    (pop),
    .head_o   (head),
    .cnt_o    (buf_cnt)
  );

  assign buf_empty = (buf_cnt == 2'd0);
  assign pop       = !buf_empty && sym_rdy_i;

  // Room checks count a same-cycle drain as free space so a steady stream
  // can be accepted every cycle with ready consumers.
  assign nz_room   = !nz_vld || nz_rdy_i;
  assign sym_room2 = buf_empty || ((buf_cnt == 2'd1) && sym_rdy_i);
  assign slot_free = (buf_cnt != 2'd2) || sym_rdy_i;

  assign rdy_o   = !rst_i && (state == S_RUN) && nz_room && sym_room2;
  assign accept  = vld_i && rdy_o;
  assign in_zero = (data_i == '0);

  // Each flush waits for its own data path to drain, then holds until taken.
  assign nz_flush_o  = (state == S_FLUSH_OUT) && !nz_vld && !nz_done;
  assign sym_flush_o = (state == S_FLUSH_OUT) && buf_empty && !sym_done;
  assign nz_fl_fire  = nz_flush_o && nz_rdy_i;
  assign sym_fl_fire = sym_flush_o && sym_rdy_i;
  assign nz_fl_ok    = nz_done || nz_fl_fire;
  assign sym_fl_ok   = sym_done || sym_fl_fire;

  // Symbol generation, run counting and FSM sequencing.
  always_comb begin
    push_a    = 1'b0;
    push_b    = 1'b0;
    sym_a     = zrle_nz_sym();
    sym_b     = zrle_nz_sym();
    run_nxt   = run_cnt;
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (accept) begin
          if (in_zero) begin
            if (run_cnt == RUN_MAX) begin
              // Run hit the longest encodable length: emit and restart.
              push_a  = 1'b1;
              sym_a   = zrle_run_sym(run_cnt);
              run_nxt = '0;
            end else begin
              run_nxt = run_cnt + 1'b1;
            end
          end else begin
            push_a  = 1'b1;
            run_nxt = '0;
            if (run_cnt != '0) begin
              // Pending run goes out ahead of the nonzero marker.
              sym_a  = zrle_run_sym(run_cnt - 1'b1);
              push_b = 1'b1;
            end
          end
          if (flush_i) state_nxt = S_FLUSH_RUN;
        end
      end
      S_FLUSH_RUN: begin
        if (run_cnt == '0) begin
          state_nxt = S_FLUSH_OUT;
        end else if (slot_free) begin
          push_a    = 1'b1;
          sym_a     = zrle_run_sym(run_cnt - 1'b1);
          run_nxt   = '0;
          state_nxt = S_FLUSH_OUT;
        end
      end
      S_FLUSH_OUT: begin
        if (nz_fl_ok && sym_fl_ok) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        state_nxt = S_RUN;
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

  // State, run counter and per-consumer flush completion flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_RUN;
      run_cnt  <= '0;
      nz_done  <= 1'b0;
      sym_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
      if (state == S_FLUSH_OUT) begin
        if (nz_fl_fire)  nz_done  <= 1'b1;
        if (sym_fl_fire) sym_done <= 1'b1;
      end else begin
        nz_done  <= 1'b0;
        sym_done <= 1'b0;
      end
    end
  end

  // Nonzero word output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nz_data <= '0;
      nz_vld  <= 1'b0;
    end else if (accept && !in_zero) begin
      nz_data <= data_i;
      nz_vld  <= 1'b1;
    end else if (nz_vld && nz_rdy_i) begin
      nz_vld  <= 1'b0;
    end
  end

  assign nz_data_o = nz_data;
  assign nz_vld_o  = nz_vld;
  assign sym_o     = head.sym;
  assign sym_len_o = head.len;
  assign sym_vld_o = !buf_empty;
  assign idle_o    = rst_i ||
                     ((state == S_IDLE) && (run_cnt == '0) && !nz_vld && buf_empty);

endmodule

`default_nettype wire

// File: tb/tb_zrle_nz_split.sv
// ============================================================================
// Module  : tb_zrle_nz_split
// Purpose : Self-checking bench for zrle_nz_split against a stream-level
//           reference encoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_zrle_nz_split;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] data_i;
  logic       flush_i;
  logic       vld_i;
  logic       rdy_o;
  logic [7:0] nz_data_o;
  logic       nz_flush_o;
  logic       nz_vld_o;
  logic       nz_rdy_i;
  logic [4:0] sym_o;
  logic [2:0] sym_len_o;
  logic       sym_flush_o;
  logic       sym_vld_o;
  logic       sym_rdy_i;
  logic       idle_o;

  always #5 clk = ~clk;

  zrle_nz_split #(.DATA_W(8), .ZRL_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .flush_i     (flush_i),
    .vld_i       (vld_i),
    .rdy_o       (rdy_o),
    .nz_data_o   (nz_data_o),
    .nz_flush_o  (nz_flush_o),
    .nz_vld_o    (nz_vld_o),
    .nz_rdy_i    (nz_rdy_i),
    .sym_o       (sym_o),
    .sym_len_o   (sym_len_o),
    .sym_flush_o (sym_flush_o),
    .sym_vld_o   (sym_vld_o),
    .sym_rdy_i   (sym_rdy_i),
    .idle_o      (idle_o)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_nz[$];
  logic [7:0] exp_sym[$];   // {sym[4:0], len[2:0]}
  int         exp_nzf = 0;
  int         exp_symf = 0;
  int         got_nzf = 0;
  int         got_symf = 0;
  int         mrun = 0;
  bit         rand_bp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: turns each offered word into the symbols and nonzero
  // words the stream should produce, in order.
  function automatic void model_word(input logic [7:0] d, input bit f);
    if (d == 8'h00) begin
      mrun++;
      if (mrun == 16) begin
        exp_sym.push_back({5'b0_1111, 3'd5});
        mrun = 0;
      end
    end else begin
      if (mrun > 0) exp_sym.push_back({1'b0, 4'(mrun - 1), 3'd5});
      mrun = 0;
      exp_sym.push_back({5'b0_0001, 3'd1});
      exp_nz.push_back(d);
    end
    if (f) begin
      if (mrun > 0) exp_sym.push_back({1'b0, 4'(mrun - 1), 3'd5});
      mrun = 0;
      exp_nzf++;
      exp_symf++;
    end
  endfunction

  // Output monitor, sampled mid-cycle where handshake signals are stable.
  logic [7:0] hold_nz;
  bit         hold_nz_v = 1'b0;
  logic [7:0] hold_sym;
  bit         hold_sym_v = 1'b0;
  always @(negedge clk) begin
    if (rst_i) begin
      hold_nz_v  = 1'b0;
      hold_sym_v = 1'b0;
    end else begin
      if (hold_nz_v) chk("nz_stable", {23'd0, nz_vld_o, nz_data_o}, {23'd0, 1'b1, hold_nz});
      if (hold_sym_v) chk("sym_stable", {23'd0, sym_vld_o, sym_o, sym_len_o}, {23'd0, 1'b1, hold_sym});
      if (nz_vld_o && nz_rdy_i) begin
        chk("nz_expected", 32'(exp_nz.size() != 0), 32'd1);
        if (exp_nz.size() != 0) chk("nz_data", 32'(nz_data_o), 32'(exp_nz.pop_front()));
      end
      if (sym_vld_o && sym_rdy_i) begin
        chk("sym_expected", 32'(exp_sym.size() != 0), 32'd1);
        if (exp_sym.size() != 0) chk("sym", 32'({sym_o, sym_len_o}), 32'(exp_sym.pop_front()));
      end
      if (nz_flush_o) chk("nz_flush_novld", 32'(nz_vld_o), 32'd0);
      if (sym_flush_o) chk("sym_flush_novld", 32'(sym_vld_o), 32'd0);
      if (nz_flush_o && nz_rdy_i) got_nzf++;
      if (sym_flush_o && sym_rdy_i) got_symf++;
      hold_nz_v  = nz_vld_o && !nz_rdy_i;
      hold_nz    = nz_data_o;
      hold_sym_v = sym_vld_o && !sym_rdy_i;
      hold_sym   = {sym_o, sym_len_o};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) begin
      nz_rdy_i  = ($urandom_range(0, 3) != 0);
      sym_rdy_i = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit f);
    int t;
    model_word(d, f);
    data_i  = d;
    flush_i = f;
    vld_i   = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rdy_o && t < 300) begin
      tick();
      @(negedge clk);
      t++;
    end
    chk("send_accept", 32'(rdy_o), 32'd1);
    tick();
    vld_i   = 1'b0;
    flush_i = 1'b0;
    data_i  = 8'($urandom);
  endtask

  task automatic finish_stream(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!idle_o && t < 400) begin
      tick();
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle"}, 32'(idle_o), 32'd1);
    chk({tag, "_nz_left"}, 32'(exp_nz.size()), 32'd0);
    chk({tag, "_sym_left"}, 32'(exp_sym.size()), 32'd0);
    chk({tag, "_nz_flushes"}, 32'(got_nzf), 32'(exp_nzf));
    chk({tag, "_sym_flushes"}, 32'(got_symf), 32'(exp_symf));
    rand_bp = 1'b0;
    tick();
    nz_rdy_i  = 1'b1;
    sym_rdy_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int pz;
    rst_i = 1'b1; vld_i = 1'b0; flush_i = 1'b0; data_i = 8'h00;
    nz_rdy_i = 1'b1; sym_rdy_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(rdy_o), 32'd0);
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_valids", 32'({nz_vld_o, sym_vld_o, nz_flush_o, sym_flush_o}), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 32'(rdy_o), 32'd1);
    tick();

    // Mixed stream: 05, 00, 00, 07 + flush
    send(8'h05, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h07, 1'b1);
    finish_stream("mixed");

    // 20 zeros -> max run then a run of 4
    for (int i = 0; i < 20; i++) send(8'h00, i == 19);
    finish_stream("zeros20");

    // Exactly 16 zeros -> one max symbol only
    for (int i = 0; i < 16; i++) send(8'h00, i == 15);
    finish_stream("zeros16");

    // Flush on the very first word
    send(8'h00, 1'b1);
    finish_stream("flush_only");

    // nz consumer stalled while nonzero words are offered
    nz_rdy_i = 1'b0;
    send(8'h11, 1'b0);
    data_i = 8'h22; vld_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("nz_bp_rdy", 32'(rdy_o), 32'd0);
      tick();
    end
    nz_rdy_i = 1'b1;
    vld_i = 1'b0;
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    finish_stream("nz_bp");

    // Symbol consumer stalled across the flush
    sym_rdy_i = 1'b0;
    send(8'h05, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("sym_bp_idle", 32'(idle_o), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("sym_bp_nz_flush_done", 32'(got_nzf), 32'(exp_nzf));
    chk("sym_bp_sym_waiting", 32'({sym_vld_o, sym_flush_o}), 32'b10);
    tick();
    sym_rdy_i = 1'b1;
    finish_stream("sym_bp");

    // Reset in the middle of a 7-zero run
    for (int i = 0; i < 7; i++) send(8'h00, 1'b0);
    rst_i = 1'b1;
    mrun = 0;
    exp_nz.delete();
    exp_sym.delete();
    @(negedge clk);
    chk("mid_rst_rdy", 32'(rdy_o), 32'd0);
    chk("mid_rst_idle", 32'(idle_o), 32'd1);
    tick();
    rst_i = 1'b0;
    exp_nzf = got_nzf;
    exp_symf = got_symf;
    @(negedge clk);
    chk("mid_rst_valids", 32'({nz_vld_o, sym_vld_o, nz_flush_o, sym_flush_o}), 32'd0);
    chk("mid_rst_rdy_after", 32'(rdy_o), 32'd1);
    tick();
    send(8'h00, 1'b0);
    send(8'h09, 1'b1);
    finish_stream("after_rst");

    // Random streams, later ones with random consumer backpressure
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(5, 40);
      pz  = (r % 2 == 0) ? 60 : 90;
      rand_bp = (r >= 3);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(1, 100) <= pz) send(8'h00, i == len - 1);
        else send(8'($urandom_range(1, 255)), i == len - 1);
      end
      finish_stream("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
